// File: rtl/naive_bus_rr_arbiter_if.sv
// Bundle of N naive_bus master ports plus the single shared slave port.
// slave modport = arbiter view (it is the slave of the masters); master modport = environment view.
interface naive_bus_rr_arbiter_if #(
    parameter int N = 2
);
    logic [N-1:0]       m_rd_req;
    logic [N-1:0][3:0]  m_rd_be;
    logic [N-1:0][31:0] m_rd_addr;
    logic [N-1:0]       m_rd_gnt;
    logic [N-1:0][31:0] m_rd_data;
    logic [N-1:0]       m_wr_req;
    logic [N-1:0][3:0]  m_wr_be;
    logic [N-1:0][31:0] m_wr_addr;
    logic [N-1:0][31:0] m_wr_data;
    logic [N-1:0]       m_wr_gnt;

    logic               s_rd_req;
    logic [3:0]         s_rd_be;
    logic [31:0]        s_rd_addr;
    logic               s_rd_gnt;
    logic [31:0]        s_rd_data;
    logic               s_wr_req;
    logic [3:0]         s_wr_be;
    logic [31:0]        s_wr_addr;
    logic [31:0]        s_wr_data;
    logic               s_wr_gnt;

    modport slave (
        input  m_rd_req, m_rd_be, m_rd_addr, m_wr_req, m_wr_be, m_wr_addr, m_wr_data,
        output m_rd_gnt, m_rd_data, m_wr_gnt,
        output s_rd_req, s_rd_be, s_rd_addr, s_wr_req, s_wr_be, s_wr_addr, s_wr_data,
        input  s_rd_gnt, s_rd_data, s_wr_gnt
    );

    modport master (
        output m_rd_req, m_rd_be, m_rd_addr, m_wr_req, m_wr_be, m_wr_addr, m_wr_data,
        input  m_rd_gnt, m_rd_data, m_wr_gnt,
        input  s_rd_req, s_rd_be, s_rd_addr, s_wr_req, s_wr_be, s_wr_addr, s_wr_data,
        output s_rd_gnt, s_rd_data, s_wr_gnt
    );
endinterface

// File: rtl/naive_bus_rr_arbiter.sv
// Round-robin arbiter: N naive_bus masters onto one slave, with lock-on-stall
// and one-cycle read data routed back to the master that owned the read.
module naive_bus_rr_arbiter_port #(
    parameter int PW  = 1,
    parameter int IDX = 0
) (
    input  logic          sel_vld,
    input  logic [PW-1:0] sel,
    input  logic          rd_req,
    input  logic          wr_req,
    input  logic          s_rd_gnt,
    input  logic          s_wr_gnt,
    input  logic          rd_own_vld,
    input  logic [PW-1:0] rd_own_idx,
    input  logic [31:0]   s_rd_data,
    output logic          rd_gnt,
    output logic          wr_gnt,
    output logic [31:0]   rd_data
);
    logic hit;
    logic own;

    assign hit     = sel_vld && (sel == PW'(IDX));
    assign own     = rd_own_vld && (rd_own_idx == PW'(IDX));
    assign rd_gnt  = hit & s_rd_gnt & rd_req;
    assign wr_gnt  = hit & s_wr_gnt & wr_req;
    assign rd_data = own ? s_rd_data : '0;
endmodule

module naive_bus_rr_arbiter #(
    parameter int N = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    naive_bus_rr_arbiter_if.slave   bus,
    output logic                    busy
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  req;
    logic [PW-1:0] ptr;
    logic          lock;
    logic [PW-1:0] lock_idx;
    logic          rd_own_vld;
    logic [PW-1:0] rd_own_idx;
    logic          sel_vld;
    logic [PW-1:0] sel;
    logic          done;

    // (base + k) mod N without a divider; k < N keeps a single wrap sufficient
    function automatic logic [PW-1:0] rot(input logic [PW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N) s = s - N;
        return PW'(s);
    endfunction

    assign req = bus.m_rd_req | bus.m_wr_req;

    // Scan from lowest priority to highest so the highest-priority hit is written last
    always_comb begin
        sel_vld = 1'b0;
        sel     = '0;
        if (lock && req[lock_idx]) begin
            sel_vld = 1'b1;
            sel     = lock_idx;
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                if (req[rot(ptr, k)]) begin
                    sel_vld = 1'b1;
                    sel     = rot(ptr, k);
                end
            end
        end
    end

    always_comb begin
        bus.s_rd_req  = 1'b0;
        bus.s_rd_be   = '0;
        bus.s_rd_addr = '0;
        bus.s_wr_req  = 1'b0;
        bus.s_wr_be   = '0;
        bus.s_wr_addr = '0;
        bus.s_wr_data = '0;
        if (sel_vld) begin
            bus.s_rd_req  = bus.m_rd_req[sel];
            bus.s_rd_be   = bus.m_rd_be[sel];
            bus.s_rd_addr = bus.m_rd_addr[sel];
            bus.s_wr_req  = bus.m_wr_req[sel];
            bus.s_wr_be   = bus.m_wr_be[sel];
            bus.s_wr_addr = bus.m_wr_addr[sel];
            bus.s_wr_data = bus.m_wr_data[sel];
        end
    end

    assign done = (bus.s_rd_req & bus.s_rd_gnt) | (bus.s_wr_req & bus.s_wr_gnt);

    for (genvar i = 0; i < N; i++) begin : g_port
        naive_bus_rr_arbiter_port #(
            .PW  (PW),
            .IDX (i)
        ) u_port (
            .sel_vld    (sel_vld),
            .sel        (sel),
            .rd_req     (bus.m_rd_req[i]),
            .wr_req     (bus.m_wr_req[i]),
            .s_rd_gnt   (bus.s_rd_gnt),
            .s_wr_gnt   (bus.s_wr_gnt),
            .rd_own_vld (rd_own_vld),
            .rd_own_idx (rd_own_idx),
            .s_rd_data  (bus.s_rd_data),
            .rd_gnt     (bus.m_rd_gnt[i]),
            .wr_gnt     (bus.m_wr_gnt[i]),
            .rd_data    (bus.m_rd_data[i])
        );
    end

    // A stalled selection is locked; a withdrawn lock falls back to the pointer scan above
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            lock       <= 1'b0;
            lock_idx   <= '0;
            rd_own_vld <= 1'b0;
            rd_own_idx <= '0;
        end else begin
            if (done) ptr <= rot(sel, 1);
            lock <= sel_vld & ~done;
            if (sel_vld && !done) lock_idx <= sel;
            rd_own_vld <= bus.s_rd_req & bus.s_rd_gnt;
            rd_own_idx <= sel;
        end
    end

    assign busy = lock;
endmodule

// File: tb/tb_naive_bus_rr_arbiter.sv
// Directed + randomized bench for naive_bus_rr_arbiter, run at N=2 and N=3 side by side
// against a cycle-level reference model of the arbitration rules.
module tb_naive_bus_rr_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]       rd_req, wr_req;
    logic [3:0][3:0]  rd_be, wr_be;
    logic [3:0][31:0] rd_addr, wr_addr, wr_data;
    logic             s_rd_gnt, s_wr_gnt;
    logic [31:0]      s_rd_data;
    logic             busy2, busy3;

    naive_bus_rr_arbiter_if #(.N(2)) b2 ();
    naive_bus_rr_arbiter_if #(.N(3)) b3 ();

    assign b2.m_rd_req = rd_req[1:0];   assign b3.m_rd_req = rd_req[2:0];
    assign b2.m_rd_be = rd_be[1:0];     assign b3.m_rd_be = rd_be[2:0];
    assign b2.m_rd_addr = rd_addr[1:0]; assign b3.m_rd_addr = rd_addr[2:0];
    assign b2.m_wr_req = wr_req[1:0];   assign b3.m_wr_req = wr_req[2:0];
    assign b2.m_wr_be = wr_be[1:0];     assign b3.m_wr_be = wr_be[2:0];
    assign b2.m_wr_addr = wr_addr[1:0]; assign b3.m_wr_addr = wr_addr[2:0];
    assign b2.m_wr_data = wr_data[1:0]; assign b3.m_wr_data = wr_data[2:0];
    assign b2.s_rd_gnt = s_rd_gnt;      assign b3.s_rd_gnt = s_rd_gnt;
    assign b2.s_wr_gnt = s_wr_gnt;      assign b3.s_wr_gnt = s_wr_gnt;
    assign b2.s_rd_data = s_rd_data;    assign b3.s_rd_data = s_rd_data;

    naive_bus_rr_arbiter #(.N(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2), .busy(busy2));
    naive_bus_rr_arbiter #(.N(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b3), .busy(busy3));

    logic [1:0][3:0]   o_rg, o_wg;
    logic [1:0][127:0] o_rd;
    logic [1:0][105:0] o_s;
    logic [1:0]        o_busy;
    assign o_rg[0] = {2'b0, b2.m_rd_gnt};
    assign o_rg[1] = {1'b0, b3.m_rd_gnt};
    assign o_wg[0] = {2'b0, b2.m_wr_gnt};
    assign o_wg[1] = {1'b0, b3.m_wr_gnt};
    assign o_rd[0] = {64'b0, b2.m_rd_data};
    assign o_rd[1] = {32'b0, b3.m_rd_data};
    assign o_s[0]  = {b2.s_rd_req, b2.s_rd_be, b2.s_rd_addr, b2.s_wr_req, b2.s_wr_be, b2.s_wr_addr, b2.s_wr_data};
    assign o_s[1]  = {b3.s_rd_req, b3.s_rd_be, b3.s_rd_addr, b3.s_wr_req, b3.s_wr_be, b3.s_wr_addr, b3.s_wr_data};
    assign o_busy  = {busy3, busy2};

    int checks = 0;
    int errors = 0;

    // Reference state: priority pointer, locked master (-1 none), master awaiting read data (-1 none)
    int m_ptr[2], m_lock[2], m_own[2];
    int n_ptr[2], n_lock[2], n_own[2];
    logic [3:0]   last_rg[2], last_wg[2];
    logic [127:0] last_rd[2];
    logic [105:0] last_s[2];
    logic         last_busy[2];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ptr[k] = 0; m_lock[k] = -1; m_own[k] = -1;
        end
    endtask

    task automatic evaluate();
        for (int k = 0; k < 2; k++) begin : g_inst
            int n, sel;
            logic [3:0] req, erg, ewg;
            logic [105:0] es;
            logic [127:0] erd;
            bit rd_done, wr_done;
            n   = (k == 0) ? 2 : 3;
            req = (rd_req | wr_req) & 4'((1 << n) - 1);
            sel = -1;
            if (m_lock[k] >= 0 && req[m_lock[k]]) sel = m_lock[k];
            else for (int j = 0; j < n; j++)
                if (sel < 0 && req[(m_ptr[k] + j) % n]) sel = (m_ptr[k] + j) % n;
            es = '0; erg = '0; ewg = '0; erd = '0;
            if (sel >= 0) begin
                es = {rd_req[sel], rd_be[sel], rd_addr[sel], wr_req[sel], wr_be[sel], wr_addr[sel], wr_data[sel]};
                erg[sel] = rd_req[sel] & s_rd_gnt;
                ewg[sel] = wr_req[sel] & s_wr_gnt;
            end
            if (m_own[k] >= 0) erd[m_own[k]*32 +: 32] = s_rd_data;
            rd_done = (erg != 0);
            wr_done = (ewg != 0);
            chk($sformatf("rd_gnt_n%0d", n), 128'(o_rg[k]), 128'(erg));
            chk($sformatf("wr_gnt_n%0d", n), 128'(o_wg[k]), 128'(ewg));
            chk($sformatf("slave_req_n%0d", n), 128'(o_s[k]), 128'(es));
            chk($sformatf("rd_data_n%0d", n), o_rd[k], erd);
            chk($sformatf("busy_n%0d", n), 128'(o_busy[k]), 128'(m_lock[k] >= 0));
            last_rg[k] = o_rg[k]; last_wg[k] = o_wg[k]; last_rd[k] = o_rd[k];
            last_s[k] = o_s[k];   last_busy[k] = o_busy[k];
            n_ptr[k]  = (rd_done || wr_done) ? (sel + 1) % n : m_ptr[k];
            n_lock[k] = (sel >= 0 && !(rd_done || wr_done)) ? sel : -1;
            n_own[k]  = rd_done ? sel : -1;
        end
    endtask

    task automatic step();
        #1 evaluate();
        @(posedge clk);
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_ptr[k] = n_ptr[k]; m_lock[k] = n_lock[k]; m_own[k] = n_own[k];
            end
        end else model_reset();
        @(negedge clk);
    endtask

    // Reset asserted mid-cycle, held across one edge, released away from the edge
    task automatic reset_now();
        rst_n = 1'b0;
        model_reset();
        #1 evaluate();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rd_req = '0; wr_req = '0; rd_be = '0; wr_be = '0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        s_rd_gnt = 1'b0; s_wr_gnt = 1'b0; s_rd_data = '0;
        model_reset();
        @(negedge clk);
        #1 evaluate();
        rst_n = 1'b1;
        @(negedge clk);

        // single reader, pass-through
        rd_req = 4'b0001; rd_addr[0] = 32'h100; rd_be[0] = 4'hf; s_rd_gnt = 1'b1;
        step();
        chk("s1_gnt", 128'(last_rg[0]), 128'(4'b0001));
        rd_req = '0; s_rd_data = 32'hDEADBEEF;
        step();
        chk("s1_data", last_rd[0], {96'b0, 32'hDEADBEEF});

        // two continuous readers alternate from master 0
        reset_now();
        rd_req = 4'b0011; rd_be[1] = 4'h3; rd_addr[1] = 32'h104;
        for (int i = 0; i < 4; i++) begin
            s_rd_data = 32'hA0 + 32'(i);
            step();
            chk($sformatf("s2_alt%0d", i), 128'(last_rg[0]), 128'((i % 2 == 0) ? 4'b0001 : 4'b0010));
        end
        rd_req = '0; s_rd_data = 32'hA4;
        step();
        chk("s2_last_data", last_rd[0], {64'b0, 32'hA4, 32'b0});

        // stalled write holds master 1 while master 0 waits
        s_rd_gnt = 1'b0;
        wr_req = 4'b0010; wr_addr[1] = 32'h200; wr_data[1] = 32'h12345678; wr_be[1] = 4'hf;
        for (int c = 1; c <= 4; c++) begin
            if (c == 2) rd_req = 4'b0001;
            s_wr_gnt = (c == 4);
            step();
            chk($sformatf("s3_wr_addr_c%0d", c), 128'(last_s[0][63:32]), 128'(32'h200));
            chk($sformatf("s3_busy_c%0d", c), 128'(last_busy[0]), 128'(c >= 2));
            chk($sformatf("s3_wr_gnt_c%0d", c), 128'(last_wg[0]), 128'((c == 4) ? 4'b0010 : 4'b0000));
        end
        wr_req = '0; s_wr_gnt = 1'b0; s_rd_gnt = 1'b1;
        step();
        chk("s3_m0_gnt_c5", 128'(last_rg[0]), 128'(4'b0001));
        chk("s3_busy_c5", 128'(last_busy[0]), 128'(0));

        // locked master withdraws; the other is served the same cycle
        rd_req = 4'b0010; rd_addr[1] = 32'h300; s_rd_gnt = 1'b0;
        step();
        rd_req = 4'b0001; s_rd_gnt = 1'b1;
        step();
        chk("s4_withdraw_gnt", 128'(last_rg[0]), 128'(4'b0001));
        chk("s4_busy_held", 128'(last_busy[0]), 128'(1));
        rd_req = '0;
        step();
        chk("s4_lock_clear", 128'(last_busy[0]), 128'(0));

        // reset while locked, then reset with a read outstanding
        rd_req = 4'b0010; s_rd_gnt = 1'b0;
        step();
        #1 chk("s5_busy_pre", 128'(o_busy[0]), 128'(1));
        reset_now();
        chk("s5_rst_busy", 128'(last_busy[0]), 128'(0));
        chk("s5_rst_gnt", 128'(last_rg[0]), 128'(0));
        rd_req = 4'b0011; s_rd_gnt = 1'b1;
        step();
        chk("s5_first_gnt", 128'(last_rg[0]), 128'(4'b0001));
        rd_req = '0; s_rd_data = 32'hBAD0BAD0;
        reset_now();
        chk("s5_rst_data", last_rd[0], 128'(0));
        step();
        chk("s5_no_stale", last_rd[0], 128'(0));

        // N=3: masters 0 and 2 alternate, master 1 idle
        reset_now();
        rd_req = 4'b0101; rd_be[2] = 4'hf; rd_addr[2] = 32'h500; s_rd_gnt = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_rd_data = 32'hC0 + 32'(i);
            step();
            chk($sformatf("s6_alt%0d", i), 128'(last_rg[1]), 128'((i % 2 == 0) ? 4'b0001 : 4'b0100));
        end
        rd_req = '0;
        step();

        // randomized traffic, with sticky requests so stalls build locks and withdrawals
        for (int i = 0; i < 400; i++) begin
            for (int m = 0; m < 4; m++) begin
                if ($urandom_range(0, 3) == 0) begin
                    rd_req[m] = 1'($urandom);
                    wr_req[m] = ($urandom_range(0, 2) == 0);
                    rd_be[m] = 4'($urandom); wr_be[m] = 4'($urandom);
                    rd_addr[m] = $urandom; wr_addr[m] = $urandom; wr_data[m] = $urandom;
                end
            end
            s_rd_gnt  = ($urandom_range(0, 2) != 0);
            s_wr_gnt  = ($urandom_range(0, 2) != 0);
            s_rd_data = $urandom;
            if ($urandom_range(0, 59) == 0) reset_now();
            else step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
